// File: rtl/multicycle_adder.sv
// multicycle_adder
//
// Multi-cycle ripple adder/subtractor. A WIDTH-bit add (or subtract) is
// computed SLICE bits per clock by reusing one SLICE-bit adder chain over
// N = WIDTH/SLICE cycles. Operands are taken through a valid/ready handshake
// and the result is offered through a second valid/ready handshake.
//
// Parameters:
//   WIDTH      operand/result width (>= 1)
//   SLICE      bits added per clock; must divide WIDTH
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operands valid
//   in_ready   block idle and able to take operands
//   a, b       operands
//   c_in       carry-in (borrow-in when sub=1)
//   sub        0 = add, 1 = subtract
//   sum        result (valid only while out_valid=1)
//   c_out      carry out of the MSB (for subtract: 1 = no borrow)
//   out_valid  result valid
//   out_ready  consumer takes the result
//   overflow   signed overflow (only with MCADD_OVERFLOW_EN defined)
//
// Build option: define MCADD_OVERFLOW_EN to add the overflow port and logic.

module multicycle_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             out_valid,
    input  logic             out_ready
`ifdef MCADD_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int N  = WIDTH / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(N - 1);

    // Reject parameter combinations that cannot be sliced evenly.
    generate
        if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_badParams
            $error("multicycle_adder: SLICE must be >= 1 and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           r_state;
    state_t           w_nextState;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_sum;
    logic             r_cOut;

    logic [SLICE-1:0] w_aSlice;
    logic [SLICE-1:0] w_bSlice;
    logic [SLICE:0]   w_sliceSum;
    logic             w_lastSlice;
    logic             w_accept;

    // Subtraction is folded into the stored operand (b inverted) and the
    // stored carry (c_in inverted) at acceptance, so sub itself is not
    // needed after that point and is not kept.
    assign w_aSlice    = r_a[r_k * SLICE +: SLICE];
    assign w_bSlice    = r_b[r_k * SLICE +: SLICE];
    assign w_sliceSum  = {1'b0, w_aSlice} + {1'b0, w_bSlice} + {{SLICE{1'b0}}, r_carry};
    assign w_lastSlice = (r_k == LAST_K);
    assign w_accept    = in_valid && in_ready;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)    w_nextState = ST_RUN;
            ST_RUN:  if (w_lastSlice) w_nextState = ST_DONE;
            ST_DONE: if (out_ready)   w_nextState = ST_IDLE;
            default:                  w_nextState = ST_IDLE;
        endcase
    end

    // FSM outputs: decoded from the registered state only.
    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
    end

    // Datapath: capture operands on acceptance, then add one slice per
    // RUN cycle, writing each slice of the result in place.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
            r_sum   <= '0;
            r_cOut  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b ^ {WIDTH{sub}};
                r_carry <= c_in ^ sub;
                r_k     <= '0;
            end else if (r_state == ST_RUN) begin
                r_sum[r_k * SLICE +: SLICE] <= w_sliceSum[SLICE-1:0];
                r_carry                     <= w_sliceSum[SLICE];
                if (w_lastSlice) begin
                    r_k    <= '0;
                    r_cOut <= w_sliceSum[SLICE];
                end else begin
                    r_k <= r_k + 1'b1;
                end
            end
        end
    end

    assign sum   = r_sum;
    assign c_out = r_cOut;

`ifdef MCADD_OVERFLOW_EN
    logic r_overflow;

    // The carry into the MSB is recovered as a ^ b ^ sum at that bit;
    // signed overflow is that carry XOR the carry out of the MSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (r_state == ST_RUN && w_lastSlice) begin
            r_overflow <= w_aSlice[SLICE-1] ^ w_bSlice[SLICE-1]
                        ^ w_sliceSum[SLICE-1] ^ w_sliceSum[SLICE];
        end
    end

    assign overflow = r_overflow;
`endif

endmodule
